// File: rtl/mem_group_xbar.sv
// Multi-lane crossbar front end and storage for the banked coefficient memory.
// Lanes reach BANKS x SUBBANKS line stores through per-target round-robin arbiters.
module mem_group_xbar #(
   parameter int  BANKS             = 4,
   parameter int  SUBBANKS          = 2,
   parameter int  COEFF_BITS        = 50,
   parameter int  COEFFS_PER_BLOCK  = 8,
   parameter int  DEPTH_PER_SUBBANK = 1024,
   parameter int  NLANE             = 4,
   parameter int  RD_LAT            = 2,
   localparam int LINE_WIDTH        = COEFF_BITS * COEFFS_PER_BLOCK,
   localparam int NT                = BANKS * SUBBANKS,
   localparam int TW                = $clog2(NT),
   localparam int RW                = $clog2(DEPTH_PER_SUBBANK),
   localparam int AW                = TW + RW
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [NLANE-1:0]                   wvalid,
   output logic [NLANE-1:0]                   wready,
   input  logic [NLANE*AW-1:0]                waddr,
   input  logic [NLANE*LINE_WIDTH-1:0]        wdata,
   input  logic [NLANE*COEFFS_PER_BLOCK-1:0]  wmask,
   input  logic [NLANE-1:0]                   rvalid_req,
   output logic [NLANE-1:0]                   rready_req,
   input  logic [NLANE*AW-1:0]                raddr,
   output logic [NLANE-1:0]                   rvalid,
   output logic [NLANE*LINE_WIDTH-1:0]        rdata,
   output logic [31:0]                        conflicts
);

   localparam int PW = (NLANE > 1) ? $clog2(NLANE) : 1;
   localparam int CW = $clog2(2 * NLANE + 1);

   if (NLANE < 1) begin : g_chk_nlane
      $error("mem_group_xbar: NLANE must be >= 1");
   end
   if (RD_LAT < 1) begin : g_chk_lat
      $error("mem_group_xbar: RD_LAT must be >= 1");
   end
   if (BANKS < 1 || (BANKS & (BANKS - 1)) != 0) begin : g_chk_banks
      $error("mem_group_xbar: BANKS must be a power of 2");
   end
   if (SUBBANKS < 1 || (SUBBANKS & (SUBBANKS - 1)) != 0) begin : g_chk_sub
      $error("mem_group_xbar: SUBBANKS must be a power of 2");
   end
   if (DEPTH_PER_SUBBANK < 1 || (DEPTH_PER_SUBBANK & (DEPTH_PER_SUBBANK - 1)) != 0) begin : g_chk_depth
      $error("mem_group_xbar: DEPTH_PER_SUBBANK must be a power of 2");
   end

   // Lowest requesting lane at or after the pointer, wrapping.
   function automatic logic [NLANE-1:0] rr_pick(input logic [NLANE-1:0] req,
                                                input logic [PW-1:0]    ptr);
      logic [NLANE-1:0] gnt;
      logic             found;
      int               idx;
      gnt   = '0;
      found = 1'b0;
      for (int i = 0; i < NLANE; i++) begin
         idx = int'(ptr) + i;
         if (idx >= NLANE) idx = idx - NLANE;
         if (!found && req[idx]) begin
            gnt[idx] = 1'b1;
            found    = 1'b1;
         end
      end
      return gnt;
   endfunction

   function automatic logic [PW-1:0] rr_next(input logic [NLANE-1:0] gnt);
      logic [PW-1:0] nxt;
      nxt = '0;
      for (int l = 0; l < NLANE; l++) begin
         if (gnt[l]) nxt = (l == NLANE - 1) ? '0 : PW'(l + 1);
      end
      return nxt;
   endfunction

   logic [TW-1:0]         wtgt [NLANE];
   logic [TW-1:0]         rtgt [NLANE];
   logic [RW-1:0]         wrow [NLANE];
   logic [RW-1:0]         rrow [NLANE];
   logic [PW-1:0]         wptr [NT];
   logic [PW-1:0]         rptr [NT];
   logic [NLANE-1:0]      wreq [NT];
   logic [NLANE-1:0]      rreq [NT];
   logic [NLANE-1:0]      wgnt [NT];
   logic [NLANE-1:0]      rgnt [NT];
   logic [NT*LINE_WIDTH-1:0] ram_flat;

   always_comb begin
      for (int l = 0; l < NLANE; l++) begin
         wtgt[l] = waddr[l*AW +: TW];
         wrow[l] = waddr[l*AW+TW +: RW];
         rtgt[l] = raddr[l*AW +: TW];
         rrow[l] = raddr[l*AW+TW +: RW];
      end
   end

   // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      wready     = '0;
      rready_req = '0;
      for (int t = 0; t < NT; t++) begin
         wreq[t] = '0;
         rreq[t] = '0;
         for (int l = 0; l < NLANE; l++) begin
            wreq[t][l] = wvalid[l]     && !rst && (wtgt[l] == TW'(t));
            rreq[t][l] = rvalid_req[l] && !rst && (rtgt[l] == TW'(t));
         end
         wgnt[t]    = rr_pick(wreq[t], wptr[t]);
         rgnt[t]    = rr_pick(rreq[t], rptr[t]);
         wready     = wready | wgnt[t];
         rready_req = rready_req | rgnt[t];
      end
   end

   // NOTE: clocked state uses non-blocking assignment so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int t = 0; t < NT; t++) begin
            wptr[t] <= '0;
            rptr[t] <= '0;
         end
      end else begin
         for (int t = 0; t < NT; t++) begin
            if (|wgnt[t]) wptr[t] <= rr_next(wgnt[t]);
            if (|rgnt[t]) rptr[t] <= rr_next(rgnt[t]);
         end
      end
   end

   for (genvar t = 0; t < NT; t++) begin : g_tgt
      logic [LINE_WIDTH-1:0]       mem [DEPTH_PER_SUBBANK];
      logic [LINE_WIDTH-1:0]       ram_q;
      logic [LINE_WIDTH-1:0]       wr_data;
      logic [COEFFS_PER_BLOCK-1:0] wr_mask;
      logic [RW-1:0]               wr_row;
      logic [RW-1:0]               rd_row;

      always_comb begin
         wr_row  = '0;
         rd_row  = '0;
         wr_data = '0;
         wr_mask = '0;
         for (int l = 0; l < NLANE; l++) begin
            if (wgnt[t][l]) begin
               wr_row  = wrow[l];
               wr_data = wdata[l*LINE_WIDTH +: LINE_WIDTH];
               wr_mask = wmask[l*COEFFS_PER_BLOCK +: COEFFS_PER_BLOCK];
            end
            if (rgnt[t][l]) rd_row = rrow[l];
         end
      end

      // NOTE: RAM array and its read register have no reset so they map onto block RAM.
      // A same-row write and read in one cycle returns the old line.
      always_ff @(posedge clk) begin
         if (|wgnt[t]) begin
            for (int c = 0; c < COEFFS_PER_BLOCK; c++) begin
               if (wr_mask[c])
                  mem[wr_row][c*COEFF_BITS +: COEFF_BITS] <= wr_data[c*COEFF_BITS +: COEFF_BITS];
            end
         end
         if (|rgnt[t]) ram_q <= mem[rd_row];
      end

      assign ram_flat[t*LINE_WIDTH +: LINE_WIDTH] = ram_q;
   end

   // First read stage: which target each lane's accepted read came from.
   logic [NLANE-1:0]      rv0;
   logic [TW-1:0]         rsel [NLANE];
   logic [LINE_WIDTH-1:0] sel_data [NLANE];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rv0 <= '0;
         for (int l = 0; l < NLANE; l++) rsel[l] <= '0;
      end else begin
         rv0 <= rready_req;
         for (int l = 0; l < NLANE; l++) begin
            if (rready_req[l]) rsel[l] <= rtgt[l];
         end
      end
   end

   always_comb begin
      for (int l = 0; l < NLANE; l++)
         sel_data[l] = ram_flat[int'(rsel[l])*LINE_WIDTH +: LINE_WIDTH];
   end

   if (RD_LAT == 1) begin : g_lat1
      assign rvalid = rv0;
      always_comb begin
         rdata = '0;
         for (int l = 0; l < NLANE; l++) rdata[l*LINE_WIDTH +: LINE_WIDTH] = sel_data[l];
      end
   end else begin : g_latn
      localparam int NS = RD_LAT - 1;
      logic [NLANE-1:0]      vq [NS];
      logic [LINE_WIDTH-1:0] dq [NS][NLANE];

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            for (int k = 0; k < NS; k++) vq[k] <= '0;
         end else begin
            vq[0] <= rv0;
            for (int k = 1; k < NS; k++) vq[k] <= vq[k-1];
         end
      end

      always_ff @(posedge clk) begin
         for (int l = 0; l < NLANE; l++) begin
            dq[0][l] <= sel_data[l];
            for (int k = 1; k < NS; k++) dq[k][l] <= dq[k-1][l];
         end
      end

      assign rvalid = vq[NS-1];
      always_comb begin
         rdata = '0;
         for (int l = 0; l < NLANE; l++) rdata[l*LINE_WIDTH +: LINE_WIDTH] = dq[NS-1][l];
      end
   end

   logic [CW-1:0] refused;
   logic [32:0]   conf_sum;

   always_comb begin
      refused = '0;
      for (int l = 0; l < NLANE; l++) begin
         refused = refused + CW'(wvalid[l] && !wready[l]) + CW'(rvalid_req[l] && !rready_req[l]);
      end
      conf_sum = {1'b0, conflicts} + 33'(refused);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)              conflicts <= '0;
      else if (conf_sum[32]) conflicts <= '1;
      else                   conflicts <= conf_sum[31:0];
   end

endmodule

// File: tb/tb_mem_group_xbar.sv
// Randomised bench for mem_group_xbar against a line-level memory and arbitration model.
// Directed scenarios cover latency, rotation, parallel targets, masks, read-old-data and reset.
module tb_mem_group_xbar;

   localparam int BANKS    = 4;
   localparam int SUBBANKS = 2;
   localparam int CB       = 50;
   localparam int CPB      = 8;
   localparam int DEPTH    = 1024;
   localparam int NLANE    = 4;
   localparam int RD_LAT   = 2;
   localparam int LW       = CB * CPB;
   localparam int NT       = BANKS * SUBBANKS;
   localparam int AW       = $clog2(NT) + $clog2(DEPTH);
   localparam int POOL     = 32;

   logic                   clk = 1'b0;
   logic                   rst;
   logic [NLANE-1:0]       wvalid, wready, rvalid_req, rready_req, rvalid;
   logic [NLANE*AW-1:0]    waddr, raddr;
   logic [NLANE*LW-1:0]    wdata, rdata;
   logic [NLANE*CPB-1:0]   wmask;
   logic [31:0]            conflicts;

   always #5 clk = ~clk;

   mem_group_xbar #(
      .BANKS(BANKS), .SUBBANKS(SUBBANKS), .COEFF_BITS(CB), .COEFFS_PER_BLOCK(CPB),
      .DEPTH_PER_SUBBANK(DEPTH), .NLANE(NLANE), .RD_LAT(RD_LAT)
   ) dut (
      .clk(clk), .rst(rst),
      .wvalid(wvalid), .wready(wready), .waddr(waddr), .wdata(wdata), .wmask(wmask),
      .rvalid_req(rvalid_req), .rready_req(rready_req), .raddr(raddr),
      .rvalid(rvalid), .rdata(rdata), .conflicts(conflicts)
   );

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;

   task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s @step %0d: got %h expected %h", tag, cyc, got, exp);
      end
   endtask

   // Reference model: flat address -> line, RR pointers, refused-request count, per-lane response queues.
   typedef struct {
      int            due;
      logic [LW-1:0] data;
   } resp_t;

   logic [LW-1:0] mem_m [int];
   int            wptr_m [NT];
   int            rptr_m [NT];
   longint        conf_m;
   resp_t         rq [NLANE][$];

   task automatic model_reset();
      for (int t = 0; t < NT; t++) begin
         wptr_m[t] = 0;
         rptr_m[t] = 0;
      end
      for (int l = 0; l < NLANE; l++) rq[l].delete();
      conf_m = 0;
   endtask

   function automatic int lane_waddr(input int l);
      return int'(waddr[l*AW +: AW]);
   endfunction

   function automatic int lane_raddr(input int l);
      return int'(raddr[l*AW +: AW]);
   endfunction

   function automatic logic [LW-1:0] rand_line();
      logic [LW-1:0] line;
      logic [63:0]   w;
      for (int c = 0; c < CPB; c++) begin
         w = {$urandom(), $urandom()};
         line[c*CB +: CB] = w[CB-1:0];
      end
      return line;
   endfunction

   task automatic clear_inputs();
      wvalid = '0; rvalid_req = '0;
      waddr  = '0; raddr      = '0;
      wdata  = '0; wmask      = '0;
   endtask

   task automatic set_wr(input int l, input int a, input logic [LW-1:0] d, input logic [CPB-1:0] m);
      wvalid[l]              = 1'b1;
      waddr[l*AW +: AW]      = AW'(a);
      wdata[l*LW +: LW]      = d;
      wmask[l*CPB +: CPB]    = m;
   endtask

   task automatic set_rd(input int l, input int a);
      rvalid_req[l]     = 1'b1;
      raddr[l*AW +: AW] = AW'(a);
   endtask

   // Called just after a falling edge with inputs driven; checks, then advances the model one cycle.
   task automatic step();
      logic [NLANE-1:0] gw, gr;
      logic             found;
      logic [LW-1:0]    line;
      resp_t            r;
      int               l, a, refused;
      #1;
      if (rst) model_reset();
      gw = '0;
      gr = '0;
      if (!rst) begin
         for (int t = 0; t < NT; t++) begin
            found = 1'b0;
            for (int i = 0; i < NLANE; i++) begin
               l = (wptr_m[t] + i) % NLANE;
               if (!found && wvalid[l] && (lane_waddr(l) % NT) == t) begin
                  gw[l] = 1'b1;
                  found = 1'b1;
               end
            end
            found = 1'b0;
            for (int i = 0; i < NLANE; i++) begin
               l = (rptr_m[t] + i) % NLANE;
               if (!found && rvalid_req[l] && (lane_raddr(l) % NT) == t) begin
                  gr[l] = 1'b1;
                  found = 1'b1;
               end
            end
         end
      end
      for (int k = 0; k < NLANE; k++) begin
         check($sformatf("wready[%0d]", k), LW'(wready[k]), LW'(gw[k]));
         check($sformatf("rready_req[%0d]", k), LW'(rready_req[k]), LW'(gr[k]));
         if (rq[k].size() > 0 && rq[k][0].due == cyc) begin
            r = rq[k].pop_front();
            check($sformatf("rvalid[%0d]", k), LW'(rvalid[k]), LW'(1));
            check($sformatf("rdata[%0d]", k), rdata[k*LW +: LW], r.data);
         end else begin
            check($sformatf("rvalid[%0d]", k), LW'(rvalid[k]), LW'(0));
         end
      end
      check("conflicts", LW'(conflicts), LW'(conf_m[31:0]));
      if (!rst) begin
         refused = 0;
         for (int k = 0; k < NLANE; k++) begin
            if (wvalid[k] && !gw[k]) refused++;
            if (rvalid_req[k] && !gr[k]) refused++;
         end
         conf_m = conf_m + refused;
         if (conf_m > 64'hFFFF_FFFF) conf_m = 64'hFFFF_FFFF;
         // Reads see the memory before this cycle's writes.
         for (int k = 0; k < NLANE; k++) begin
            if (gr[k]) begin
               a      = lane_raddr(k);
               r.due  = cyc + RD_LAT;
               r.data = mem_m.exists(a) ? mem_m[a] : 'x;
               rq[k].push_back(r);
               rptr_m[a % NT] = (k + 1) % NLANE;
            end
         end
         for (int k = 0; k < NLANE; k++) begin
            if (gw[k]) begin
               a    = lane_waddr(k);
               line = mem_m.exists(a) ? mem_m[a] : 'x;
               for (int c = 0; c < CPB; c++)
                  if (wmask[k*CPB + c]) line[c*CB +: CB] = wdata[k*LW + c*CB +: CB];
               mem_m[a] = line;
               wptr_m[a % NT] = (k + 1) % NLANE;
            end
         end
      end
      cyc++;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      clear_inputs();
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [LW-1:0] d, ones, twos;
      clear_inputs();
      model_reset();
      rst = 1'b0;
      #2 rst = 1'b1;
      @(negedge clk);
      step();
      step();
      rst = 1'b0;

      // Fill the address pool (rows 0..3, all targets) with known lines.
      for (int b = 0; b < POOL; b += NLANE) begin
         clear_inputs();
         for (int l = 0; l < NLANE; l++) set_wr(l, b + l, rand_line(), '1);
         step();
      end
      idle(2);

      // Write then read 0x005 on another lane.
      d = rand_line();
      clear_inputs(); set_wr(0, 5, d, '1); step();
      clear_inputs(); set_rd(1, 5); step();
      idle(RD_LAT + 1);

      // Four lanes fight over target 0.
      for (int i = 0; i < 8; i++) begin
         clear_inputs();
         for (int l = 0; l < NLANE; l++) set_rd(l, l * NT);
         step();
      end
      idle(RD_LAT + 1);

      // Four lanes on four different targets.
      clear_inputs();
      for (int l = 0; l < NLANE; l++) set_rd(l, l);
      step();
      idle(RD_LAT + 1);

      // Partial-mask write over a line of ones.
      for (int c = 0; c < CPB; c++) begin
         ones[c*CB +: CB] = CB'(1);
         twos[c*CB +: CB] = CB'(2);
      end
      clear_inputs(); set_wr(0, 22, ones, '1);         step();
      clear_inputs(); set_wr(3, 22, twos, 8'b0000_0101); step();
      clear_inputs(); set_rd(2, 22);                    step();
      idle(RD_LAT + 1);

      // Same-cycle write and read of one row, then read again.
      clear_inputs(); set_wr(0, 27, rand_line(), '1); set_rd(1, 27); step();
      clear_inputs(); set_rd(1, 27); step();
      idle(RD_LAT + 1);

      // Random traffic over the pool.
      for (int i = 0; i < 300; i++) begin
         clear_inputs();
         for (int l = 0; l < NLANE; l++) begin
            if ($urandom_range(0, 1) == 1)
               set_wr(l, $urandom_range(0, POOL - 1), rand_line(), CPB'($urandom_range(0, 255)));
            if ($urandom_range(0, 1) == 1)
               set_rd(l, $urandom_range(0, POOL - 1));
         end
         step();
      end
      idle(RD_LAT + 1);

      // Reset with reads in flight, including one contended target to move its pointer.
      clear_inputs();
      for (int l = 0; l < NLANE; l++) set_rd(l, l * NT);
      step();
      clear_inputs();
      for (int l = 0; l < NLANE; l++) set_rd(l, l + 4);
      step();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      clear_inputs();
      set_rd(1, 0); set_rd(2, NT); set_rd(3, 2 * NT);
      step();
      idle(RD_LAT + 2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
